// File: rtl/instruction_fetch_unit_pkg.sv
// rv32_fetch_pkg: shared types and constants for the RV32 instruction fetch unit.
package rv32_fetch_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // ADDI x0,x0,0
  localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Sequential word address, wraps modulo 2^32.
  function automatic word_t pc_next(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction memory request/response bus.
interface instruction_fetch_unit_if;
  import rv32_fetch_pkg::*;

  word_t IMEM_ADDR;
  logic  IMEM_READ;
  word_t IMEM_READDATA;
  logic  IMEM_BUSY;

  modport master (output IMEM_ADDR, output IMEM_READ,
                  input  IMEM_READDATA, input IMEM_BUSY);
  modport slave  (input  IMEM_ADDR, input IMEM_READ,
                  output IMEM_READDATA, output IMEM_BUSY);
endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// fetch_buffer: one-entry holding register for a word fetched while the
// downstream stage was stalled.
module fetch_buffer
  import rv32_fetch_pkg::*;
(
  input  logic  CLK,
  input  logic  RESET,
  input  logic  load,
  input  logic  clear,
  input  word_t d_instr,
  input  word_t d_pc,
  output logic  q_valid,
  output word_t q_instr,
  output word_t q_pc
);

  // Capture on load, drop on clear (clear wins).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_valid <= 1'b0;
      q_instr <= '0;
      q_pc    <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: RV32 IF stage, one instruction per cycle with
// branch redirect, memory wait-state and downstream stall handling.
// Optional feature: define INSTR_BUFFER_EN to keep a word returned during a
// stall in a one-entry buffer instead of refetching it.
module instruction_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
)(
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            STALL,
  input  logic                            BRANCH_TAKEN,
  input  word_t                           BRANCH_TARGET,
  instruction_fetch_unit_if.master        imem,
  output word_t                           INSTRUCTION,
  output word_t                           PC,
  output word_t                           PC_PLUS_4,
  output logic                            FETCH_VALID
);

  fetch_state_t state, state_n;
  word_t        fetch_pc, fetch_pc_n;
  word_t        instr_n, pc_n, pc4_n;
  logic         valid_n;
  logic         armed;
  logic [1:0]   unused_tgt_bits;

  assign unused_tgt_bits = BRANCH_TARGET[1:0];

`ifdef INSTR_BUFFER_EN
  logic  buf_load, buf_clear, buf_valid;
  word_t buf_instr, buf_pc;

  fetch_buffer u_buf (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (buf_load),
    .clear   (buf_clear),
    .d_instr (imem.IMEM_READDATA),
    .d_pc    (fetch_pc),
    .q_valid (buf_valid),
    .q_instr (buf_instr),
    .q_pc    (buf_pc)
  );
`endif

  assign imem.IMEM_ADDR = fetch_pc;
  assign imem.IMEM_READ = (state == REQ);

  // Reset release stage: the first edge after RESET drops leaves the FSM in
  // IDLE, so the first valid instruction lands on the third edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) armed <= 1'b0;
    else       armed <= 1'b1;
  end

  // State, fetch PC and registered fetch outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      fetch_pc    <= {RESET_PC[31:2], 2'b00};
      INSTRUCTION <= NOP_INSTR;
      PC          <= '0;
      PC_PLUS_4   <= '0;
      FETCH_VALID <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      INSTRUCTION <= instr_n;
      PC          <= pc_n;
      PC_PLUS_4   <= pc4_n;
      FETCH_VALID <= valid_n;
    end
  end

  // Next state and next output values; priority branch > stall > busy.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    instr_n    = INSTRUCTION;
    pc_n       = PC;
    pc4_n      = PC_PLUS_4;
    valid_n    = FETCH_VALID;
`ifdef INSTR_BUFFER_EN
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
`endif
    if (BRANCH_TAKEN) begin
      state_n    = REQ;
      fetch_pc_n = {BRANCH_TARGET[31:2], 2'b00};
      instr_n    = NOP_INSTR;
      valid_n    = 1'b0;
`ifdef INSTR_BUFFER_EN
      buf_clear  = 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: if (armed) state_n = REQ;
        REQ: begin
          if (STALL) begin
`ifdef INSTR_BUFFER_EN
            if (!imem.IMEM_BUSY) begin
              buf_load   = 1'b1;
              fetch_pc_n = pc_next(fetch_pc);
              state_n    = HOLD;
            end
`endif
          end else if (imem.IMEM_BUSY) begin
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
          end else begin
            instr_n    = imem.IMEM_READDATA;
            pc_n       = fetch_pc;
            pc4_n      = pc_next(fetch_pc);
            valid_n    = 1'b1;
            fetch_pc_n = pc_next(fetch_pc);
          end
        end
        HOLD: begin
`ifdef INSTR_BUFFER_EN
          if (!STALL && buf_valid) begin
            instr_n   = buf_instr;
            pc_n      = buf_pc;
            pc4_n     = pc_next(buf_pc);
            valid_n   = 1'b1;
            buf_clear = 1'b1;
            state_n   = REQ;
          end
`else
          state_n = REQ;
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
